// File: rtl/spi_receive_con.sv
// Quad-line SPI pixel receiver: synchronises CS/DCLK/data, assembles MSB-first words, tags raster position.
// Optional macro FINAL_PIXEL_RESYNC_EN: the sideband final-pixel flag realigns the raster counters.
module spi_receive_con #(
    parameter int DATA_WIDTH  = 8,
    parameter int LINES       = 4,
    parameter int H_PIXELS    = 640,
    parameter int V_PIXELS    = 360,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = $clog2(H_PIXELS * V_PIXELS)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [LINES-1:0]      chip_data_in,
    input  logic                  chip_clk_in,
    input  logic                  chip_sel_in,
    input  logic                  final_pixel_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic [9:0]            hcount_out,
    output logic [8:0]            vcount_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  frame_done_out,
    output logic                  error_out,
    output logic                  busy_out
);

    localparam int BEATS = DATA_WIDTH / LINES;
    localparam int BCW   = $clog2(BEATS + 2);

    localparam logic [BCW-1:0]        BEAT_LAST_IDX = BCW'(BEATS - 1);
    localparam logic [BCW-1:0]        BEAT_FULL     = BCW'(BEATS);
    localparam logic [BCW-1:0]        BEAT_MAX      = BCW'(BEATS + 1);
    localparam logic [9:0]            H_LAST        = 10'(H_PIXELS - 1);
    localparam logic [8:0]            V_LAST        = 9'(V_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0]            cs_sync;
    logic [SYNC_STAGES-1:0]            dclk_sync;
    logic [SYNC_STAGES-1:0]            fin_sync;
    logic [SYNC_STAGES-1:0][LINES-1:0] data_sync;
    logic                              cs_prev;
    logic                              dclk_prev;

    logic                  cs_s;
    logic                  dclk_s;
    logic                  fin_s;
    logic [LINES-1:0]      data_s;
    logic                  dclk_rise;
    logic                  cs_fall;
    logic                  cs_rise;

    logic [DATA_WIDTH-1:0] shreg;
    logic [BCW-1:0]        beat_cnt;
    logic                  fin_latched;

    logic [9:0]            hcount;
    logic [8:0]            vcount;
    logic [ADDR_WIDTH-1:0] addr;

    logic                  word_ok;
    logic                  word_bad;
    logic                  at_last;

    // All four inputs share the same depth so a data beat stays aligned with its DCLK edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cs_sync   <= '1;
            dclk_sync <= '0;
            fin_sync  <= '0;
            data_sync <= '0;
            cs_prev   <= 1'b1;
            dclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], chip_sel_in};
            dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], chip_clk_in};
            fin_sync  <= {fin_sync[SYNC_STAGES-2:0], final_pixel_in};
            data_sync <= {data_sync[SYNC_STAGES-2:0], chip_data_in};
            cs_prev   <= cs_sync[SYNC_STAGES-1];
            dclk_prev <= dclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign dclk_s    = dclk_sync[SYNC_STAGES-1];
    assign fin_s     = fin_sync[SYNC_STAGES-1];
    assign data_s    = data_sync[SYNC_STAGES-1];
    assign dclk_rise = dclk_s & ~dclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        word_ok    = 1'b0;
        word_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (cs_rise) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                word_ok    = (beat_cnt == BEAT_FULL);
                word_bad   = (beat_cnt != BEAT_FULL);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_out = (state != IDLE);
    assign at_last  = (hcount == H_LAST) && (vcount == V_LAST);

    // Beat counter saturates one past a full word so overruns stay distinguishable.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            shreg       <= '0;
            beat_cnt    <= '0;
            fin_latched <= 1'b0;
        end else if (state == IDLE && cs_fall) begin
            shreg       <= '0;
            beat_cnt    <= '0;
            fin_latched <= 1'b0;
        end else if (state == RECV && dclk_rise) begin
            shreg <= {shreg[DATA_WIDTH-LINES-1:0], data_s};
            if (beat_cnt != BEAT_MAX) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (beat_cnt == BEAT_LAST_IDX) begin
                fin_latched <= fin_s;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            data_out       <= '0;
            data_valid_out <= 1'b0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            addr_out       <= '0;
            frame_done_out <= 1'b0;
            error_out      <= 1'b0;
            hcount         <= '0;
            vcount         <= '0;
            addr           <= '0;
        end else begin
            data_valid_out <= 1'b0;
            frame_done_out <= 1'b0;
            error_out      <= 1'b0;
            if (word_ok) begin
                data_out       <= shreg;
                hcount_out     <= hcount;
                vcount_out     <= vcount;
                addr_out       <= addr;
                data_valid_out <= 1'b1;
`ifdef FINAL_PIXEL_RESYNC_EN
                if (fin_latched) begin
                    hcount         <= '0;
                    vcount         <= '0;
                    addr           <= '0;
                    frame_done_out <= 1'b1;
                    error_out      <= ~at_last;
                end else
`endif
                if (at_last) begin
                    hcount         <= '0;
                    vcount         <= '0;
                    addr           <= '0;
                    frame_done_out <= 1'b1;
                end else if (hcount == H_LAST) begin
                    hcount <= '0;
                    vcount <= vcount + 1'b1;
                    addr   <= addr + 1'b1;
                end else begin
                    hcount <= hcount + 1'b1;
                    addr   <= addr + 1'b1;
                end
            end else if (word_bad) begin
                error_out <= 1'b1;
            end
        end
    end

`ifndef FINAL_PIXEL_RESYNC_EN
    logic unused_fin;
    assign unused_fin = fin_latched;
`endif

endmodule

// File: tb/tb_spi_receive_con.sv
// Directed bench for spi_receive_con: vector table plus frame-wrap, CS-high, latency and reset sequences.
// Uses a reduced 16x3 raster so a whole frame fits in a short run.
module tb_spi_receive_con;

    localparam int DW   = 8;
    localparam int LN   = 4;
    localparam int TB_H = 16;
    localparam int TB_V = 3;
    localparam int SS   = 2;
    localparam int AW   = 6;
    localparam int NPIX = TB_H * TB_V;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic [LN-1:0] chip_data_in = '0;
    logic          chip_clk_in = 1'b0;
    logic          chip_sel_in = 1'b1;
    logic          final_pixel_in = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid_out;
    logic [9:0]    hcount_out;
    logic [8:0]    vcount_out;
    logic [AW-1:0] addr_out;
    logic          frame_done_out;
    logic          error_out;
    logic          busy_out;

    spi_receive_con #(
        .DATA_WIDTH (DW),
        .LINES      (LN),
        .H_PIXELS   (TB_H),
        .V_PIXELS   (TB_V),
        .SYNC_STAGES(SS),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .chip_data_in  (chip_data_in),
        .chip_clk_in   (chip_clk_in),
        .chip_sel_in   (chip_sel_in),
        .final_pixel_in(final_pixel_in),
        .data_out      (data_out),
        .data_valid_out(data_valid_out),
        .hcount_out    (hcount_out),
        .vcount_out    (vcount_out),
        .addr_out      (addr_out),
        .frame_done_out(frame_done_out),
        .error_out     (error_out),
        .busy_out      (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Strobe monitor: counters only ever increase; tests take differences.
    int            n_valid = 0;
    int            n_err   = 0;
    int            n_frame = 0;
    int            n_busy  = 0;
    logic [DW-1:0] cap_data = '0;
    logic [9:0]    cap_h = '0;
    logic [8:0]    cap_v = '0;
    logic [AW-1:0] cap_a = '0;

    always @(negedge clk_in) begin
        if (data_valid_out) begin
            n_valid  = n_valid + 1;
            cap_data = data_out;
            cap_h    = hcount_out;
            cap_v    = vcount_out;
            cap_a    = addr_out;
        end
        if (error_out)      n_err   = n_err + 1;
        if (frame_done_out) n_frame = n_frame + 1;
        if (busy_out)       n_busy  = n_busy + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_beats(input logic [DW-1:0] w, input int beats, input int half, input logic fin);
        logic [DW-1:0] sh;
        sh = w;
        @(negedge clk_in);
        chip_sel_in    = 1'b0;
        final_pixel_in = fin;
        chip_clk_in    = 1'b0;
        repeat (half) @(negedge clk_in);
        for (int b = 0; b < beats; b++) begin
            chip_data_in = sh[DW-1 -: LN];
            sh = sh << LN;
            repeat (half) @(negedge clk_in);
            chip_clk_in = 1'b1;
            repeat (half) @(negedge clk_in);
            chip_clk_in = 1'b0;
        end
        repeat (half) @(negedge clk_in);
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int beats, input int half, input logic fin);
        send_beats(w, beats, half, fin);
        chip_sel_in    = 1'b1;
        final_pixel_in = 1'b0;
        repeat (SS + 6) @(negedge clk_in);
    endtask

    typedef struct {
        logic [DW-1:0] word;
        int            beats;
        int            half;
        logic          fin;
        int            exp_valid;
        int            exp_err;
        int            exp_frame;
        logic [DW-1:0] exp_data;
        logic [9:0]    exp_h;
        logic [8:0]    exp_v;
        logic [AW-1:0] exp_a;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_v, b_e, b_f, b_b, pos, lat;

        vecs[0] = '{8'hA5, 2, 50, 1'b0, 1, 0, 0, 8'hA5, 10'd0, 9'd0, 6'd0};
        vecs[1] = '{8'h3C, 2, 3,  1'b0, 1, 0, 0, 8'h3C, 10'd1, 9'd0, 6'd1};
        vecs[2] = '{8'hFF, 1, 3,  1'b0, 0, 1, 0, 8'h00, 10'd0, 9'd0, 6'd0};
        vecs[3] = '{8'h12, 3, 3,  1'b0, 0, 1, 0, 8'h00, 10'd0, 9'd0, 6'd0};
        vecs[4] = '{8'h5A, 2, 3,  1'b0, 1, 0, 0, 8'h5A, 10'd2, 9'd0, 6'd2};
        vecs[5] = '{8'h00, 2, 4,  1'b0, 1, 0, 0, 8'h00, 10'd3, 9'd0, 6'd3};
`ifdef FINAL_PIXEL_RESYNC_EN
        vecs[6] = '{8'h81, 2, 3,  1'b1, 1, 1, 1, 8'h81, 10'd4, 9'd0, 6'd4};
        vecs[7] = '{8'h7E, 2, 3,  1'b0, 1, 0, 0, 8'h7E, 10'd0, 9'd0, 6'd0};
        pos = 1;
`else
        vecs[6] = '{8'h81, 2, 3,  1'b1, 1, 0, 0, 8'h81, 10'd4, 9'd0, 6'd4};
        vecs[7] = '{8'h7E, 2, 3,  1'b0, 1, 0, 0, 8'h7E, 10'd5, 9'd0, 6'd5};
        pos = 6;
`endif

        // Reset state
        repeat (3) @(negedge clk_in);
        check("reset outputs",
              {data_out, data_valid_out, hcount_out, vcount_out, addr_out, frame_done_out, error_out, busy_out},
              '0);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);

        foreach (vecs[i]) begin
            b_v = n_valid; b_e = n_err; b_f = n_frame;
            send_word(vecs[i].word, vecs[i].beats, vecs[i].half, vecs[i].fin);
            check($sformatf("vec%0d valid count", i), n_valid - b_v, vecs[i].exp_valid);
            check($sformatf("vec%0d error count", i), n_err - b_e, vecs[i].exp_err);
            check($sformatf("vec%0d frame count", i), n_frame - b_f, vecs[i].exp_frame);
            if (vecs[i].exp_valid != 0) begin
                check($sformatf("vec%0d data", i), cap_data, vecs[i].exp_data);
                check($sformatf("vec%0d hcount", i), cap_h, vecs[i].exp_h);
                check($sformatf("vec%0d vcount", i), cap_v, vecs[i].exp_v);
                check($sformatf("vec%0d addr", i), cap_a, vecs[i].exp_a);
            end
        end

        // Run to the end of the frame with data = index
        b_v = n_valid; b_e = n_err; b_f = n_frame;
        for (int i = pos; i < NPIX; i++) begin
            send_word(8'(i), 2, 3, 1'b0);
            check($sformatf("frame word %0d data", i), cap_data, 8'(i));
        end
        check("frame valid count", n_valid - b_v, NPIX - pos);
        check("frame error count", n_err - b_e, 0);
        check("frame done count", n_frame - b_f, 1);
        check("last hcount", cap_h, TB_H - 1);
        check("last vcount", cap_v, TB_V - 1);
        check("last addr", cap_a, NPIX - 1);
        send_word(8'hE7, 2, 3, 1'b0);
        check("wrap addr", cap_a, 0);
        check("wrap hcount", cap_h, 0);
        check("wrap vcount", cap_v, 0);

        // DCLK activity with CS high must be ignored
        b_v = n_valid; b_e = n_err; b_b = n_busy;
        for (int k = 0; k < 5; k++) begin
            chip_data_in = 4'(k + 3);
            repeat (3) @(negedge clk_in);
            chip_clk_in = 1'b1;
            repeat (3) @(negedge clk_in);
            chip_clk_in = 1'b0;
        end
        repeat (8) @(negedge clk_in);
        check("cs high valid", n_valid - b_v, 0);
        check("cs high error", n_err - b_e, 0);
        check("cs high busy", n_busy - b_b, 0);

        // Latency from raw CS rise to the valid strobe
        send_beats(8'h96, 2, 3, 1'b0);
        chip_sel_in = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk_in);
            #1;
            if (lat == 0 && data_valid_out) lat = k;
        end
        check("strobe latency", lat, SS + 2);
        repeat (4) @(negedge clk_in);
        check("latency word data", cap_data, 8'h96);
        check("latency word addr", cap_a, 1);

        // Asynchronous reset in the middle of a word
        send_beats(8'hC3, 1, 3, 1'b0);
        check("busy mid word", busy_out, 1'b1);
        rst_in = 1'b0;
        #1;
        check("reset mid word outputs",
              {data_out, data_valid_out, hcount_out, vcount_out, addr_out, frame_done_out, error_out, busy_out},
              '0);
        chip_sel_in = 1'b1;
        chip_clk_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        b_v = n_valid; b_e = n_err;
        send_word(8'h3C, 2, 3, 1'b0);
        check("post reset valid", n_valid - b_v, 1);
        check("post reset error", n_err - b_e, 0);
        check("post reset data", cap_data, 8'h3C);
        check("post reset addr", cap_a, 0);
        check("post reset hcount", cap_h, 0);
        check("post reset held data", data_out, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
